// File: rtl/d_jb_predict_pkg.sv
// Shared decode constants, branch/jump code enums and BHT clear-FSM states.
package d_jb_predict_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef enum logic [2:0] {
    BOP_NONE = 3'd0,
    BOP_BEQ  = 3'd1,
    BOP_BNE  = 3'd2,
    BOP_BLEZ = 3'd3,
    BOP_BGTZ = 3'd4,
    BOP_BLTZ = 3'd5,
    BOP_BGEZ = 3'd6
  } bop_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10
  } jump_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } bht_state_e;

endpackage

// File: rtl/d_jb_bht.sv
// Branch history table: 2^IDX_W saturating counters, clear walk FSM and update.
// Only built when D_JB_BHT_EN is defined.
`ifdef D_JB_BHT_EN
module d_jb_bht
  import d_jb_predict_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_msb,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic             i_clr,
  output logic             o_busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0] cnt_mem [DEPTH];

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_data;
  logic [CNT_W-1:0] upd_cnt;

  // Asynchronous read so a same-cycle lookup sees the pre-update value.
  assign upd_cnt  = cnt_mem[i_upd_idx];
  assign o_rd_msb = cnt_mem[i_rd_idx][CNT_W-1];
  assign o_busy   = busy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = i_upd_idx;
    wr_data = upd_cnt;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = ptr_q;
        wr_data = CNT_WEAK;
        if (i_clr) begin
          ptr_d = '0;
        end else if (ptr_q == {IDX_W{1'b1}}) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (i_upd_valid) begin
          wr_en = 1'b1;
          if (i_upd_taken)
            wr_data = (upd_cnt == CNT_MAX) ? upd_cnt : upd_cnt + 1'b1;
          else
            wr_data = (upd_cnt == '0) ? upd_cnt : upd_cnt - 1'b1;
        end
        if (i_clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && i_rst_n)
      cnt_mem[wr_idx] <= wr_data;
  end

endmodule
`endif

// File: rtl/d_jb_predict.sv
// Decode-stage jump/branch decode, direction prediction and perf counters.
// Define D_JB_BHT_EN to build the dynamic BHT; otherwise prediction is static.
module d_jb_predict
  import d_jb_predict_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_con_valid,
  input  logic [5:0]        i_con_instru,
  input  logic [5:0]        i_con_func,
  input  logic              i_con_rt,
  input  logic              i_con_offs_neg,
  input  logic [31:0]       i_con_pc,
  input  logic              i_upd_valid,
  input  logic [31:0]       i_upd_pc,
  input  logic              i_upd_taken,
  input  logic              i_upd_mispred,
  input  logic              i_bht_clr,
  output logic [1:0]        o_con_jump,
  output logic [2:0]        o_con_bop,
  output logic              o_con_aluPC4,
  output logic              o_con_is_br,
  output logic              o_con_pred_taken,
  output logic              o_bht_busy,
  output logic [PERF_W-1:0] o_br_cnt,
  output logic [PERF_W-1:0] o_mis_cnt
);

  jump_e             jump;
  bop_e              bop;
  logic              link_pc4;
  logic              is_br;
  logic [PERF_W-1:0] br_cnt_q, br_cnt_d;
  logic [PERF_W-1:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    jump     = JMP_NONE;
    bop      = BOP_NONE;
    link_pc4 = 1'b0;
    if (i_con_valid) begin
      case (i_con_instru)
        OP_BEQ:    bop = BOP_BEQ;
        OP_BNE:    bop = BOP_BNE;
        OP_BLEZ:   bop = BOP_BLEZ;
        OP_BGTZ:   bop = BOP_BGTZ;
        OP_REGIMM: bop = i_con_rt ? BOP_BGEZ : BOP_BLTZ;
        OP_J:      jump = JMP_J;
        OP_JAL: begin
          jump     = JMP_J;
          link_pc4 = 1'b1;
        end
        OP_SPECIAL: if (i_con_func == FN_JR) jump = JMP_JR;
        default: ;
      endcase
    end
  end

  assign is_br        = (bop != BOP_NONE);
  assign o_con_jump   = jump;
  assign o_con_bop    = bop;
  assign o_con_aluPC4 = link_pc4;
  assign o_con_is_br  = is_br;

`ifdef D_JB_BHT_EN
  logic bht_msb;
  logic bht_busy;
  logic unused_pc_bits;

  d_jb_bht #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_bht (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_idx    (i_con_pc[IDX_W+1:2]),
    .o_rd_msb    (bht_msb),
    .i_upd_valid (i_upd_valid),
    .i_upd_idx   (i_upd_pc[IDX_W+1:2]),
    .i_upd_taken (i_upd_taken),
    .i_clr       (i_bht_clr),
    .o_busy      (bht_busy)
  );

  // While the table is being walked its contents are stale, so fall back to static.
  assign o_con_pred_taken = is_br & (bht_busy ? i_con_offs_neg : bht_msb);
  assign o_bht_busy       = bht_busy;
  assign unused_pc_bits   = ^{i_con_pc[31:IDX_W+2], i_con_pc[1:0],
                              i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};
`else
  logic unused_bht_inputs;

  assign o_con_pred_taken  = is_br & i_con_offs_neg;
  assign o_bht_busy        = 1'b0;
  assign unused_bht_inputs = ^{i_con_pc, i_upd_pc, i_upd_taken, i_bht_clr};
`endif

  always_comb begin
    br_cnt_d  = br_cnt_q + PERF_W'(i_upd_valid);
    mis_cnt_d = mis_cnt_q + PERF_W'(i_upd_valid & i_upd_mispred);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;

endmodule
